// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: per-lane RISC-V immediate decoder feeding a 2-entry skid FIFO.
// Decode happens on the input side. Outputs come straight from the head entry.

// Single-lane immediate extraction and format classification.
module imm_gen_lane #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic            lane_valid,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            vld
);
  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  // Raw signed fields; a size cast to XLEN sign-extends them.
  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [20:0] imm_j;
  logic [2:0]         f3;

  assign imm_i = instr[31:20];
  assign imm_s = {instr[31:25], instr[11:7]};
  assign imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign f3    = instr[14:12];

  // Opcode decode; unknown opcodes and empty lanes produce fmt 0 / imm 0.
  always_comb begin
    imm = '0;
    fmt = FMT_NONE;
    case (instr[6:0])
      7'b0000011, 7'b1100111: begin
        fmt = FMT_I;
        imm = XLEN'(imm_i);
      end
      7'b0010011: begin
        fmt = FMT_I;
        // Shift-immediates carry only the shamt; funct7 is not part of it.
        if (f3 == 3'b001 || f3 == 3'b101) imm = XLEN'(instr[24:20]);
        else                              imm = XLEN'(imm_i);
      end
      7'b0100011: begin
        fmt = FMT_S;
        imm = XLEN'(imm_s);
      end
      7'b1100011: begin
        fmt = FMT_B;
        imm = XLEN'(imm_b);
      end
      7'b0110111, 7'b0010111: begin
        fmt = FMT_U;
        imm = XLEN'(imm_u);
      end
      7'b1101111: begin
        fmt = FMT_J;
        imm = XLEN'(imm_j);
      end
      7'b1110011: begin
        if (f3 != 3'b000) begin
          fmt = FMT_Z;
          imm = XLEN'(instr[19:15]);
        end
      end
      default: begin
        fmt = FMT_NONE;
        imm = '0;
      end
    endcase
    if (!lane_valid) begin
      fmt = FMT_NONE;
      imm = '0;
    end
  end

  assign vld = (fmt != FMT_NONE);
endmodule

// Bundle-level wrapper: LANES decoders plus a 2-entry FIFO of decoded bundles.
module imm_gen_pipe #(
  parameter int LANES = 2,
  parameter int XLEN  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*32-1:0]   in_instr,
  input  logic [LANES-1:0]      in_lane_valid,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*XLEN-1:0] out_imm,
  output logic [LANES*3-1:0]    out_fmt,
  output logic [LANES-1:0]      out_lane_valid
);
  typedef struct packed {
    logic [LANES-1:0][XLEN-1:0] imm;
    logic [LANES-1:0][2:0]      fmt;
    logic [LANES-1:0]           lv;
  } entry_t;

  logic [LANES-1:0][XLEN-1:0] dec_imm;
  logic [LANES-1:0][2:0]      dec_fmt;
  logic [LANES-1:0]           dec_lv;
  entry_t                     dec;
  entry_t                     mem [2];
  entry_t                     head;
  logic                       wr_ptr;
  logic                       rd_ptr;
  logic [1:0]                 count;
  logic                       alive;
  logic                       push;
  logic                       pop;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    imm_gen_lane #(.XLEN(XLEN)) u_lane (
      .instr      (in_instr[32*g +: 32]),
      .lane_valid (in_lane_valid[g]),
      .imm        (dec_imm[g]),
      .fmt        (dec_fmt[g]),
      .vld        (dec_lv[g])
    );
  end

  assign dec = '{imm: dec_imm, fmt: dec_fmt, lv: dec_lv};

  // Handshake is a function of registered state only; alive keeps in_ready
  // low while reset is held and lifts it at the first edge afterwards.
  assign in_ready  = alive && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  assign head           = mem[rd_ptr];
  assign out_imm        = head.imm;
  assign out_fmt        = head.fmt;
  assign out_lane_valid = head.lv;

  // Reset-release marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  // FIFO control: flush wins over push/pop; pointers wrap modulo 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; cleared on reset so every output port reads 0 while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= dec;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: a 2-lane/32-bit instance plus a 1-lane/64-bit one.
module tb_imm_gen_pipe;
  typedef struct packed {
    logic [63:0] imm;
    logic [5:0]  fmt;
    logic [1:0]  lv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_instr = '0;
  logic [1:0]  in_lane_valid = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_imm;
  logic [5:0]  out_fmt;
  logic [1:0]  out_lane_valid;

  logic        in_valid64 = 1'b0;
  logic        in_ready64;
  logic [31:0] in_instr64 = '0;
  logic [0:0]  in_lv64 = 1'b1;
  logic        flush64 = 1'b0;
  logic        out_valid64;
  logic        out_ready64 = 1'b1;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
  logic [0:0]  out_lv64;

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [66:0] q64[$];

  imm_gen_pipe #(.LANES(2), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_lane_valid(in_lane_valid), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_lane_valid(out_lane_valid)
  );

  imm_gen_pipe #(.LANES(1), .XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
    .in_instr(in_instr64), .in_lane_valid(in_lv64), .flush(flush64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_lane_valid(out_lv64)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare each bundle the consumer takes against the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      if (q.size() == 0) chk("unexpected_bundle", {out_imm, out_fmt, out_lane_valid}, '0);
      else chk("bundle", {out_imm, out_fmt, out_lane_valid}, q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid64 && out_ready64) begin
      if (q64.size() == 0) chk("unexpected_bundle64", {out_imm64, out_fmt64}, '0);
      else chk("bundle64", {out_imm64, out_fmt64}, q64.pop_front());
    end
  end

  // Offer a bundle and hold it until accepted (bounded).
  task automatic send(input logic [63:0] ins, input logic [1:0] lv, input exp_t e);
    bit ok = 0;
    in_valid = 1'b1; in_instr = ins; in_lane_valid = lv;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin q.push_back(e); ok = 1; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 1, 0);
  endtask

  task automatic send64(input logic [31:0] ins, input logic [66:0] e);
    bit ok = 0;
    in_valid64 = 1'b1; in_instr64 = ins;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready64) begin q64.push_back(e); ok = 1; end
      @(posedge clk); #1;
    end
    in_valid64 = 1'b0;
    if (!ok) chk("send64_timeout", 1, 0);
  endtask

  logic [63:0] v_ins [8];
  logic [1:0]  v_lv  [8];
  exp_t        v_exp [8];

  initial begin
    // {lane1, lane0} instructions with hand-computed decode results.
    v_ins[0] = {32'hFE000CE3, 32'hFFF00093}; v_lv[0] = 2'b11;
    v_exp[0] = '{imm: {32'hFFFFFFF8, 32'hFFFFFFFF}, fmt: {3'd3, 3'd1}, lv: 2'b11};
    v_ins[1] = {32'h3002D073, 32'hFFDFF06F}; v_lv[1] = 2'b11;
    v_exp[1] = '{imm: {32'h00000005, 32'hFFFFFFFC}, fmt: {3'd6, 3'd5}, lv: 2'b11};
    v_ins[2] = {32'hFE112E23, 32'h40305093}; v_lv[2] = 2'b11;
    v_exp[2] = '{imm: {32'hFFFFFFFC, 32'h00000003}, fmt: {3'd2, 3'd1}, lv: 2'b11};
    v_ins[3] = {32'hFFF00093, 32'h12345037}; v_lv[3] = 2'b01;
    v_exp[3] = '{imm: {32'h00000000, 32'h12345000}, fmt: {3'd0, 3'd4}, lv: 2'b01};
    v_ins[4] = {32'h00000073, 32'h00000033}; v_lv[4] = 2'b11;
    v_exp[4] = '{imm: 64'h0, fmt: 6'd0, lv: 2'b00};
    v_ins[5] = {32'h7FF00067, 32'h80002083}; v_lv[5] = 2'b11;
    v_exp[5] = '{imm: {32'h000007FF, 32'hFFFFF800}, fmt: {3'd1, 3'd1}, lv: 2'b11};
    v_ins[6] = {32'hFFFFF017, 32'hFFF09093}; v_lv[6] = 2'b11;
    v_exp[6] = '{imm: {32'hFFFFF000, 32'h0000001F}, fmt: {3'd4, 3'd1}, lv: 2'b11};
    v_ins[7] = {32'hFFF00093, 32'hFFF00093}; v_lv[7] = 2'b00;
    v_exp[7] = '{imm: 64'h0, fmt: 6'd0, lv: 2'b00};

    // Reset state.
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {out_imm, out_fmt, out_lane_valid}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", in_ready, 1);

    // One-cycle latency from an empty FIFO, then the full vector table streamed.
    send(v_ins[0], v_lv[0], v_exp[0]);
    chk("latency_out_valid", out_valid, 1);
    for (int i = 1; i < 8; i++) send(v_ins[i], v_lv[i], v_exp[i]);

    // 64-bit instance: U-type sign extension and I-type all-ones.
    send64(32'h800000B7, {64'hFFFFFFFF80000000, 3'd4});
    send64(32'hFFF00093, {64'hFFFFFFFFFFFFFFFF, 3'd1});

    // Backpressure: two accepted, third blocked, head stable, then drain in order.
    repeat (4) @(posedge clk); #1;
    out_ready = 1'b0;
    send(v_ins[1], v_lv[1], v_exp[1]);
    send(v_ins[2], v_lv[2], v_exp[2]);
    in_valid = 1'b1; in_instr = v_ins[5]; in_lane_valid = v_lv[5];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_in_ready", in_ready, 0);
      chk("head_stable", {out_valid, out_imm, out_fmt}, {1'b1, v_exp[1].imm, v_exp[1].fmt});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(v_ins[5], v_lv[5], v_exp[5]);
    repeat (4) @(posedge clk); #1;
    chk("drained_in_ready", in_ready, 1);
    chk("drained_out_valid", out_valid, 0);

    // Flush at count 2 with a bundle offered.
    out_ready = 1'b0;
    send(v_ins[0], v_lv[0], v_exp[0]);
    send(v_ins[3], v_lv[3], v_exp[3]);
    in_valid = 1'b1; in_instr = v_ins[6]; in_lane_valid = v_lv[6]; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; q.delete();
    chk("flush2_out_valid", out_valid, 0);
    chk("flush2_in_ready", in_ready, 1);

    // Flush at count 1 with a bundle offered: the push must be dropped.
    send(v_ins[2], v_lv[2], v_exp[2]);
    in_valid = 1'b1; in_instr = v_ins[6]; in_lane_valid = v_lv[6]; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush1_out_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    send(v_ins[6], v_lv[6], v_exp[6]);

    // Asynchronous reset mid-stream.
    repeat (3) @(posedge clk); #1;
    out_ready = 1'b0;
    send(v_ins[1], v_lv[1], v_exp[1]);
    send(v_ins[2], v_lv[2], v_exp[2]);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    chk("arst_out_valid", out_valid, 0);
    chk("arst_outputs", {out_imm, out_fmt, out_lane_valid}, 0);
    chk("arst_in_ready", in_ready, 0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("arst_ready_after", in_ready, 1);
    chk("arst_empty", out_valid, 0);
    send(v_ins[0], v_lv[0], v_exp[0]);

    for (int i = 0; i < 50 && (q.size() != 0 || q64.size() != 0); i++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    chk("scoreboard64_empty", q64.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
